// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner.
// After reset (or a clear_req pulse) it zeroes registers 1..2**ADDR_WIDTH-1,
// then arbitrates two writeback requesters onto the single write port
// round-robin. The INIT/RUN state is visible on init_done (high in RUN).
//
// Handshake: a requester raises valid together with addr/data and holds all
// three stable until it observes ready. The write is accepted in any cycle
// where valid && ready. ready is combinational from valid, the last grant and
// clear_req. At most one ready is high per cycle. ready never waits on the
// register file, so one write per cycle is sustained.
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    last_grant_q, last_grant_d;
  logic                    rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;

  logic                    clr_last;
  logic                    accept;
  logic                    grant_idx;
  logic [ADDR_WIDTH-1:0]   grant_addr;
  logic [DATA_WIDTH-1:0]   grant_data;

  // The clear sequence ends on the edge that issues the all-ones address.
  assign clr_last = (clr_addr_q == ADDR_MAX);

  // State register; reset restarts the clear sequence immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  // Next state: leave INIT after the last clear write, re-enter on clear_req.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (clr_last)  state_d = ST_RUN;
      ST_RUN:  if (clear_req) state_d = ST_INIT;
      default: state_d = ST_INIT;
    endcase
  end

  // Ready generation: lone requester wins; on contention the one that did
  // not win last time wins. Nothing is granted in INIT or on a clear_req cycle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == ST_RUN && !clear_req) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant_q;
        req1_ready = !last_grant_q;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign accept     = req0_ready | req1_ready;
  assign grant_idx  = req1_ready;
  assign grant_addr = req1_ready ? req1_addr : req0_addr;
  assign grant_data = req1_ready ? req1_data : req0_data;

  // Write-port datapath: clear writes in INIT, granted writes in RUN.
  // Address 0 completes its handshake but never reaches the register file.
  always_comb begin
    clr_addr_d   = clr_addr_q;
    last_grant_d = last_grant_q;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (state_q == ST_INIT) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = clr_addr_q;
      rf_wdata_d = '0;
      clr_addr_d = clr_last ? ADDR_ONE : clr_addr_q + ADDR_ONE;
    end else if (accept) begin
      last_grant_d = grant_idx;
      rf_wen_d     = (grant_addr != '0);
      rf_waddr_d   = grant_addr;
      rf_wdata_d   = grant_data;
    end
  end

  // Datapath registers; last_grant resets to 1 so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_addr_q   <= ADDR_ONE;
      last_grant_q <= 1'b1;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      clr_addr_q   <= clr_addr_d;
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a transaction-level reference model and,
// at the end, by comparing a model register file with the one the DUT wrote.
module tb_rf_write_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          clear_req;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          init_done;

  rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .init_done  (init_done)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: either clearing (next address to zero) or running
  // (round-robin between requesters). m_rf is the register file contents the
  // specification implies; dut_rf is what the DUT's write port actually did.
  bit            m_run;
  int            m_clr;
  int            m_last;
  bit            exp_wen;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  logic [DW-1:0] m_rf   [NREG];
  logic [DW-1:0] dut_rf [NREG];

  // Observations from the most recent step
  int obs_g;
  bit obs_wen;
  bit obs_init;

  task automatic model_reset();
    m_run     = 1'b0;
    m_clr     = 1;
    m_last    = 1;
    exp_wen   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  // Who should be granted right now (-1 for nobody).
  function automatic int model_grant();
    if (!rst || !m_run || clear_req) return -1;
    if (req0_valid && req1_valid)    return (m_last == 0) ? 1 : 0;
    if (req0_valid)                  return 0;
    if (req1_valid)                  return 1;
    return -1;
  endfunction

  task automatic model_edge(input int g, input logic [AW-1:0] ga, input logic [DW-1:0] gd);
    if (!m_run) begin
      exp_wen     = 1'b1;
      exp_waddr   = AW'(m_clr);
      exp_wdata   = '0;
      m_rf[m_clr] = '0;
      if (m_clr == NREG - 1) begin
        m_run = 1'b1;
        m_clr = 1;
      end else begin
        m_clr++;
      end
    end else if (clear_req) begin
      m_run   = 1'b0;
      exp_wen = 1'b0;
    end else if (g >= 0) begin
      exp_waddr = ga;
      exp_wdata = gd;
      exp_wen   = (ga != 0);
      if (ga != 0) m_rf[ga] = gd;
      m_last = g;
    end else begin
      exp_wen = 1'b0;
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising
  // edge, return 1 time unit after it so the caller can drive new inputs.
  task automatic step();
    int            g;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    @(negedge clk);
    g = model_grant();
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    check("rf_wen", rf_wen, exp_wen);
    check("rf_waddr", rf_waddr, exp_waddr);
    check("rf_wdata", rf_wdata, exp_wdata);
    check("init_done", init_done, m_run);
    obs_g    = req0_ready ? 0 : (req1_ready ? 1 : -1);
    obs_wen  = rf_wen;
    obs_init = init_done;
    if (rf_wen) dut_rf[rf_waddr] = rf_wdata;
    ga = (g == 1) ? req1_addr : req0_addr;
    gd = (g == 1) ? req1_data : req0_data;
    @(posedge clk);
    if (rst) model_edge(g, ga, gd);
    #1;
  endtask

  // Step until init_done is seen, counting clear writes; bounded.
  task automatic run_until_init(output int n);
    bit seen;
    n    = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      if (obs_wen) n++;
      if (obs_init) seen = 1'b1;
    end
    if (!seen) check("init_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- driver helpers ----------------
  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return '0;
    return AW'($urandom_range(1, NREG - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    int n;
    int want [4];
    want = '{0, 1, 0, 1};

    for (int i = 0; i < NREG; i++) begin
      m_rf[i]   = $urandom;
      dut_rf[i] = m_rf[i];
    end
    clear_req  = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    model_reset();
    #1 rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;

    // Clear sequence after power-up
    run_until_init(n);
    check("clear_len", n, 31);

    // Contention: req0 wins first, then alternation; data refreshed per accept
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      check("grant_order", obs_g, want[i]);
      if (obs_g == 0) req0_data = req0_data + 32'h100;
      if (obs_g == 1) req1_data = req1_data + 32'h100;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check("contend_last_wen", obs_wen, 1);

    // Single requester
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    step();
    check("single_ready", obs_g, 0);
    req0_valid = 1'b0;
    step();
    check("single_wen", obs_wen, 1);
    step();
    check("single_idle", obs_wen, 0);

    // Address 0 is handshaken but dropped; it still counts for round-robin
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFF;
    step();
    check("a0_ready", obs_g, 1);
    req1_valid = 1'b0;
    step();
    check("a0_wen", obs_wen, 0);
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
    step();
    check("a0_next_rr", obs_g, 0);
    req0_valid = 1'b0;
    step();
    check("a0_then_req1", obs_g, 1);
    req1_valid = 1'b0;

    // clear_req in the same cycle as contention
    req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
    clear_req  = 1'b1;
    step();
    check("clr_no_grant", obs_g, -1);
    clear_req = 1'b0;
    run_until_init(n);
    check("reclear_len", n, 31);
    check("pending_granted", obs_g != -1, 1);
    for (int k = 0; k < 4 && (req0_valid || req1_valid); k++) begin
      if (obs_g == 0) req0_valid = 1'b0;
      if (obs_g == 1) req1_valid = 1'b0;
      if (req0_valid || req1_valid) step();
    end
    check("pending_drained", req0_valid | req1_valid, 0);

    // Asynchronous reset between edges during contention
    req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'h88;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    repeat (2) begin
      step();
      if (obs_g == 0) req0_data = req0_data + 1;
      if (obs_g == 1) req1_data = req1_data + 1;
    end
    #2 rst = 1'b0;
    #1;
    check("arst_wen", rf_wen, 0);
    check("arst_init", init_done, 0);
    check("arst_ready0", req0_ready, 0);
    check("arst_ready1", req1_ready, 0);
    model_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    run_until_init(n);
    check("arst_clear_len", n, 31);

    // Random traffic with occasional clear pulses
    for (int c = 0; c < 600; c++) begin
      step();
      clear_req = 1'b0;
      if (obs_g == 0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_addr  = rand_addr();
        req0_data  = $urandom;
      end
      if (obs_g == 1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_addr  = rand_addr();
        req1_data  = $urandom;
      end
      if ($urandom_range(0, 59) == 0) clear_req = 1'b1;
    end

    // Drain: finish any clear and let the last write issue
    clear_req  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (40) step();

    for (int i = 0; i < NREG; i++) check("rf_final", dut_rf[i], m_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the run is a few thousand cycles at most
  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
